// File: rtl/spi_fnd_pkg.sv
// Shared types and defaults for the SPI counter receive path and the FND display path.
package spi_fnd_pkg;

  localparam int FRAME_BITS_DEFAULT = 16;
  localparam int MAX_COUNT_DEFAULT  = 9999;
  localparam int COUNT_W            = 14;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_CLEAR = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

endpackage

// File: rtl/spi_counter_rx_sync_edge.sv
// Two-flop synchronizer with an extra history flop for single-cycle rise/fall pulses.
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {3{RESET_VAL}};
    else       sync_q <= sync_d;
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_counter_rx.sv
// SPI mode-0 slave that receives command frames to update a 0..MAX_COUNT display counter
// and streams the counter value back on miso during each frame.
module spi_counter_rx
  import spi_fnd_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT,
  parameter int MAX_COUNT  = MAX_COUNT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclk,
  input  logic               mosi,
  input  logic               cs_n,
  output logic               miso,
  output logic [COUNT_W-1:0] counter,
  output logic               rx_done,
  output logic               rx_err
);

  localparam logic [4:0]         BIT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0]         BIT_SAT  = 5'(FRAME_BITS + 1);
  localparam logic [COUNT_W-1:0] MAX_CNT  = COUNT_W'(MAX_COUNT);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic cs_level, cs_rise, cs_fall;

  sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .d(sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .d(mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .d(cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [FRAME_BITS-1:0]  shadow_q, shadow_d;
  logic [4:0]             bitcnt_q, bitcnt_d;
  logic [COUNT_W-1:0]     counter_q, counter_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [1:0]             settle_q, settle_d;
  logic                   armed_q, armed_d;
  logic                   frame_start;
  cmd_e                   cmd;
  logic [COUNT_W-1:0]     data;

  assign cmd  = cmd_e'(shift_q[FRAME_BITS-1 -: 2]);
  assign data = shift_q[COUNT_W-1:0];

  // The cs_n synchronizer resets to "high", so a bus held low across reset release
  // looks like a falling edge; frames are only accepted once a real high level is seen.
  assign frame_start = (state_q == IDLE) && cs_fall && armed_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_start) state_d = SHIFT;
      SHIFT:   if (cs_rise)     state_d = COMMIT;
      COMMIT:                   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    miso = (state_q == SHIFT) ? shadow_q[FRAME_BITS-1] : 1'b0;
  end

  always_comb begin
    shift_d   = shift_q;
    shadow_d  = shadow_q;
    bitcnt_d  = bitcnt_q;
    counter_d = counter_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    settle_d  = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d   = armed_q | ((settle_q == 2'd2) && cs_level);

    if (frame_start) begin
      shift_d  = '0;
      bitcnt_d = '0;
      shadow_d = FRAME_BITS'(counter_q);
    end

    // cs_n rising edge wins over any sclk edge seen in the same cycle.
    if ((state_q == SHIFT) && !cs_rise) begin
      if (sclk_rise) begin
        shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
        if (bitcnt_q != BIT_SAT) bitcnt_d = bitcnt_q + 5'd1;
      end
      if (sclk_fall) shadow_d = {shadow_q[FRAME_BITS-2:0], 1'b0};
    end

    if (state_q == COMMIT) begin
      if (bitcnt_q != BIT_FULL) begin
        err_d = 1'b1;
      end else begin
        unique case (cmd)
          CMD_NOP:   done_d = 1'b1;
          CMD_LOAD: begin
            if (data <= MAX_CNT) begin
              counter_d = data;
              done_d    = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          CMD_CLEAR: begin
            counter_d = '0;
            done_d    = 1'b1;
          end
          default:   err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q   <= '0;
      shadow_q  <= '0;
      bitcnt_q  <= '0;
      counter_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      settle_q  <= '0;
      armed_q   <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      bitcnt_q  <= bitcnt_d;
      counter_q <= counter_d;
      done_q    <= done_d;
      err_q     <= err_d;
      settle_q  <= settle_d;
      armed_q   <= armed_d;
    end
  end

  assign counter = counter_q;
  assign rx_done = done_q;
  assign rx_err  = err_q;

endmodule

// File: tb/tb_spi_counter_rx.sv
// Randomised and directed SPI frames against a frame-level reference model; a monitor
// pops the expected commit result whenever rx_done or rx_err pulses.
`timescale 1ns/1ps
module tb_spi_counter_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk, mosi, cs_n;
  logic        miso;
  logic [13:0] counter;
  logic        rx_done, rx_err;

  spi_counter_rx #(.FRAME_BITS(16), .MAX_COUNT(9999)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .counter(counter), .rx_done(rx_done), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 1 = rx_done, 2 = rx_err
    int cnt;
    int at_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level reference: decides the outcome of a completed frame from its length and content.
  task automatic model_commit(input logic [63:0] bits, input int n);
    exp_t e;
    int v, cmd, data;
    v    = int'(bits[15:0]);
    cmd  = v / 16384;
    data = v % 16384;
    e.kind = 2;
    if (n == 16) begin
      if (cmd == 0) e.kind = 1;
      else if (cmd == 1 && data <= 9999) begin e.kind = 1; model_cnt = data; end
      else if (cmd == 2) begin e.kind = 1; model_cnt = 0; end
    end
    e.cnt    = model_cnt;
    e.at_cyc = cyc + 4;
    exp_q.push_back(e);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    wait_clk(4);
    m = miso;
    sclk = 1'b1;
    wait_clk(4);
    sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [63:0] bits, input int n, input int gap);
    int   start_cnt, m, word;
    logic mb;
    start_cnt = model_cnt;
    word = 0;
    m = (n < 16) ? n : 16;
    check("miso_idle_before", int'(miso), 0);
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < n; i++) begin
      spi_bit(bits[n-1-i], mb);
      if (i < 16) word = (word << 1) | int'(mb);
    end
    wait_clk(4);
    check("miso_stream", word, start_cnt >> (16 - m));
    cs_n = 1'b1;
    model_commit(bits, n);
    wait_clk(gap);
    check("miso_idle_after", int'(miso), 0);
  endtask

  // Scoreboard monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rx_done && rx_err) check("pulse_exclusive", 1, 0);
    if (rx_done || rx_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", int'({rx_err, rx_done}), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", int'({rx_err, rx_done}), e.kind);
        check("commit_counter", int'(counter), e.cnt);
        check("commit_latency", cyc, e.at_cyc);
      end
    end
  end

  initial begin
    #600us;
    $display("FAIL watchdog: simulation time limit reached, got %0d expected 0 pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  logic [63:0] bits;
  logic        mb;
  int          n, sel, cmd, data;

  initial begin
    reset = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
    wait_clk(3);
    check("reset_counter", int'(counter), 0);
    check("reset_done", int'(rx_done), 0);
    check("reset_err", int'(rx_err), 0);
    check("reset_miso", int'(miso), 0);
    reset = 1'b0;
    wait_clk(6);

    spi_frame({48'd0, 2'b01, 14'd6666}, 16, 6);
    check("load_6666", int'(counter), 6666);

    spi_frame({48'd0, 2'b01, 14'd10000}, 16, 6);
    check("load_10000_rejected", int'(counter), 6666);
    spi_frame({48'd0, 2'b01, 14'd9999}, 16, 6);
    check("load_9999", int'(counter), 9999);

    spi_frame({48'd0, 2'b01, 14'd1234}, 16, 6);
    bits = {$urandom, $urandom};
    spi_frame(bits, 16, 6);
    spi_frame(64'h8000, 16, 6);
    check("clear", int'(counter), 0);

    spi_frame({48'd0, 2'b01, 14'd321}, 16, 6);
    bits = {$urandom, $urandom};
    spi_frame(bits, 12, 6);
    bits = {$urandom, $urandom};
    spi_frame(bits, 20, 6);
    spi_frame(64'hC005, 16, 6);
    spi_frame(64'h4005, 48, 6);
    check("bad_frames_unchanged", int'(counter), 321);

    // Reset in the middle of a LOAD 100 frame, released while cs_n is still low.
    bits = 64'h4064;
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 8; i++) spi_bit(bits[15-i], mb);
    reset = 1'b1;
    model_cnt = 0;
    wait_clk(2);
    check("abort_counter", int'(counter), 0);
    check("abort_miso", int'(miso), 0);
    reset = 1'b0;
    for (int i = 8; i < 16; i++) spi_bit(bits[15-i], mb);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(12);
    check("abort_no_commit", int'(counter), 0);
    spi_frame(64'h4064, 16, 6);
    check("load_100", int'(counter), 100);

    spi_frame({48'd0, 2'b01, 14'd1}, 16, 4);
    check("b2b_1", int'(counter), 1);
    spi_frame({48'd0, 2'b01, 14'd2}, 16, 4);
    check("b2b_2", int'(counter), 2);
    spi_frame(64'h0000, 16, 4);
    check("b2b_nop", int'(counter), 2);

    for (int k = 0; k < 30; k++) begin
      n    = ($urandom_range(0, 9) < 8) ? 16 : int'($urandom_range(1, 24));
      cmd  = int'($urandom_range(0, 3));
      sel  = int'($urandom_range(0, 3));
      data = (sel == 0) ? 9999 : (sel == 1) ? 10000 :
             (sel == 2) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
      bits = {$urandom, $urandom};
      if (n == 16) bits[15:0] = 16'(cmd * 16384 + data);
      spi_frame(bits, n, int'($urandom_range(4, 8)));
      check("rand_counter", int'(counter), model_cnt);
    end

    wait_clk(20);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
